mem_stage: RTL and testbench

// - MEM pipeline stage between EX and WB: holds one instruction, waits for the data-SRAM

---
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for data-SRAM responses, extends load data, packs the WB bus.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   es_to_ms_valid/bus    instruction from EX (130-bit field bundle, pc in the low bits)
//   ms_allowin            MEM can accept from EX this cycle
//   ws_allowin            WB can accept this cycle
//   ms_to_ws_valid/bus    instruction to WB (125 bits, load result replaces alu_result)
//   flush                 WB exception/ERET kills MEM this cycle
//   es_owed_on_flush      EX's in-flight request is also killed by this flush
//   data_sram_data_ok/rdata  in-order SRAM response
//   ms_fwd_bus            {rf_we gated by valid, dest, result} for ID bypass
//   ms_load_busy          load still waiting for its data
//   ms_ex_eret            MEM holds an exception or ERET
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          es_to_ms_valid,
    input  logic [129:0]  es_to_ms_bus,
    output logic          ms_allowin,
    input  logic          ws_allowin,
    output logic          ms_to_ws_valid,
    output logic [124:0]  ms_to_ws_bus,
    input  logic          flush,
    input  logic          es_owed_on_flush,
    input  logic          data_sram_data_ok,
    input  logic [31:0]   data_sram_rdata,
    output logic [40:0]   ms_fwd_bus,
    output logic          ms_load_busy,
    output logic          ms_ex_eret
);
    localparam int CW = CANCEL_W + 2;

    logic                ms_valid;
    logic [129:0]        bus_r;
    logic [31:0]         data_buf;
    logic                data_buf_vld;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic [31:0] pc, alu_result, rdata_sel, load_val, result;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [2:0]  ld_type;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        mem_req, is_load, ex, c0_eret;
    logic        cnt_zero, ms_ready_go, accept, leave, owed_ms, cnt_dec;
    logic [CW-1:0]       cnt_sum;
    logic [CANCEL_W-1:0] cnt_next;

    assign pc         = bus_r[31:0];
    assign alu_result = bus_r[63:32];
    assign dest       = bus_r[68:64];
    assign rf_we      = bus_r[72:69];
    assign mem_req    = bus_r[73];
    assign is_load    = bus_r[74];
    assign ld_type    = bus_r[77:75];
    assign ex         = bus_r[83];
    assign c0_eret    = bus_r[95];

    assign cnt_zero    = cancel_cnt == '0;
    assign ms_ready_go = !mem_req || ex || data_buf_vld || (data_sram_data_ok && cnt_zero);
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign leave       = ms_to_ws_valid && ws_allowin;
    // The response for this instruction arrives now (stale responses are still being drained otherwise).
    assign accept      = data_sram_data_ok && cnt_zero && ms_valid && mem_req && !ex && !data_buf_vld;
    // This instruction still owes a response that will now arrive for nobody.
    assign owed_ms     = ms_valid && mem_req && !ex && !data_buf_vld && !accept;
    assign cnt_dec     = data_sram_data_ok && !cnt_zero;

    always_comb begin
        rdata_sel = data_buf_vld ? data_buf : data_sram_rdata;
        ld_byte   = rdata_sel[{alu_result[1:0], 3'b000} +: 8];
        ld_half   = alu_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        load_val  = ld_type == 3'd1 ? {{24{ld_byte[7]}}, ld_byte} :
                    ld_type == 3'd2 ? {24'b0, ld_byte} :
                    ld_type == 3'd3 ? {{16{ld_half[15]}}, ld_half} :
                    ld_type == 3'd4 ? {16'b0, ld_half} : rdata_sel;
        result    = is_load ? load_val : alu_result;
        cnt_sum   = {2'b00, cancel_cnt} + (flush ? CW'(owed_ms) + CW'(es_owed_on_flush) : '0) - CW'(cnt_dec);
        cnt_next  = cnt_sum > CW'({CANCEL_W{1'b1}}) ? {CANCEL_W{1'b1}} : cnt_sum[CANCEL_W-1:0];
    end

    assign ms_to_ws_bus = {bus_r[129:78], rf_we, dest, result, pc};
    assign ms_fwd_bus   = {rf_we & {4{ms_valid}}, dest, result};
    assign ms_load_busy = ms_valid && is_load && !ms_ready_go;
    assign ms_ex_eret   = ms_valid && (ex || c0_eret);

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid     <= 1'b0;
            bus_r        <= '0;
            data_buf     <= '0;
            data_buf_vld <= 1'b0;
            cancel_cnt   <= '0;
        end else begin
            ms_valid <= flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
            if (es_to_ms_valid && ms_allowin)
                bus_r <= es_to_ms_bus;
            if (accept && !ws_allowin)
                data_buf <= data_sram_rdata;
            data_buf_vld <= (flush || leave) ? 1'b0 : (accept && !ws_allowin) ? 1'b1 : data_buf_vld;
            cancel_cnt   <= cnt_next;
            assert (cnt_sum <= CW'({CANCEL_W{1'b1}}));
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a field-level reference model.
module tb_mem_stage;
    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic [31:0] badv;
        logic [10:0] c0;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic [2:0]  ld_type;
        logic        is_load;
        logic        mem_req;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } ins_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         es_to_ms_valid = 1'b0;
    logic [129:0] es_to_ms_bus = '0;
    logic         ms_allowin;
    logic         ws_allowin = 1'b1;
    logic         ms_to_ws_valid;
    logic [124:0] ms_to_ws_bus;
    logic         flush = 1'b0;
    logic         es_owed_on_flush = 1'b0;
    logic         data_sram_data_ok = 1'b0;
    logic [31:0]  data_sram_rdata = '0;
    logic [40:0]  ms_fwd_bus;
    logic         ms_load_busy;
    logic         ms_ex_eret;

    int errors = 0;
    int checks = 0;
    ins_t i;
    int k, d, w;
    logic [31:0] r, r1, r2, r3;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .flush(flush), .es_owed_on_flush(es_owed_on_flush),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ms_fwd_bus(ms_fwd_bus), .ms_load_busy(ms_load_busy), .ms_ex_eret(ms_ex_eret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ld(input logic [2:0] t, input logic [1:0] a, input logic [31:0] dat);
        int unsigned b, h;
        int ai;
        ai = int'(a);
        b = (dat >> (8 * ai)) & 32'hFF;
        h = (dat >> (16 * (ai / 2))) & 32'hFFFF;
        case (t)
            3'd1:    return b >= 128 ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return h >= 32768 ? h - 65536 : h;
            3'd4:    return h;
            default: return dat;
        endcase
    endfunction

    function automatic logic [31:0] exp_res(input ins_t x, input logic [31:0] dat);
        return x.is_load ? ref_ld(x.ld_type, x.alu[1:0], dat) : x.alu;
    endfunction

    function automatic logic [124:0] exp_bus(input ins_t x, input logic [31:0] res);
        return {x.tlbwi, x.tlbr, x.badv, x.c0, x.bd, x.ex, x.excode, x.rf_we, x.dest, res, x.pc};
    endfunction

    function automatic ins_t rnd(input logic ld, input logic mr, input logic [2:0] lt);
        ins_t x;
        x.tlbwi = 1'($urandom); x.tlbr = 1'($urandom); x.badv = $urandom;
        x.c0 = 11'($urandom); x.bd = 1'($urandom); x.ex = 1'b0; x.excode = 5'($urandom);
        x.ld_type = lt; x.is_load = ld; x.mem_req = mr;
        x.rf_we = 4'($urandom); x.dest = 5'($urandom); x.alu = $urandom; x.pc = $urandom;
        return x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input ins_t x);
        es_to_ms_bus = x;
        es_to_ms_valid = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input ins_t x, input logic [31:0] dat);
        chk({tag, "_valid"}, 128'(ms_to_ws_valid), 128'(1'b1));
        chk({tag, "_bus"}, 128'(ms_to_ws_bus), 128'(exp_bus(x, exp_res(x, dat))));
        chk({tag, "_fwd"}, 128'(ms_fwd_bus), 128'({x.rf_we, x.dest, exp_res(x, dat)}));
        chk({tag, "_eret"}, 128'(ms_ex_eret), 128'(x.ex | x.c0[10]));
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("rst_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rst_fwd_we", 128'(ms_fwd_bus[40:37]), 128'(4'b0));
        chk("rst_busy", 128'(ms_load_busy), 128'(1'b0));
        chk("rst_eret", 128'(ms_ex_eret), 128'(1'b0));

        // LB from byte 3, response in the entry cycle
        i = rnd(1'b1, 1'b1, 3'd1);
        i.alu[1:0] = 2'b11;
        enter(i);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80123456;
        #1;
        chk_out("lb", i, 32'h80123456);
        chk("lb_lit", 128'(ms_fwd_bus[31:0]), 128'(32'hFFFFFF80));
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("lb_gone", 128'(ms_to_ws_valid), 128'(1'b0));

        // LHU upper half, response three cycles late
        i = rnd(1'b1, 1'b1, 3'd4);
        i.alu[1] = 1'b1;
        enter(i);
        repeat (3) begin
            #1;
            chk("lhu_busy", 128'(ms_load_busy), 128'(1'b1));
            chk("lhu_wait", 128'(ms_to_ws_valid), 128'(1'b0));
            chk("lhu_allowin", 128'(ms_allowin), 128'(1'b0));
            tick();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF0000;
        #1;
        chk_out("lhu", i, 32'hBEEF0000);
        chk("lhu_lit", 128'(ms_fwd_bus[31:0]), 128'(32'h0000BEEF));
        chk("lhu_nobusy", 128'(ms_load_busy), 128'(1'b0));
        tick();
        data_sram_data_ok = 1'b0;

        // LW response while WB stalls is buffered
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11223344;
        #1;
        chk("lw_buf_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        #1;
        chk_out("lw_buf1", i, 32'h11223344);
        chk("lw_buf_allowin", 128'(ms_allowin), 128'(1'b0));
        tick();
        data_sram_rdata = $urandom; ws_allowin = 1'b1;
        #1;
        chk_out("lw_buf2", i, 32'h11223344);
        chk("lw_buf_lit", 128'(ms_fwd_bus[31:0]), 128'(32'h11223344));
        tick();
        #1;
        chk("lw_buf_gone", 128'(ms_to_ws_valid), 128'(1'b0));

        // flush kills a waiting LW plus EX's request: two responses must be dropped
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        tick();
        flush = 1'b1; es_owed_on_flush = 1'b1;
        #1;
        chk("fl_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();
        flush = 1'b0; es_owed_on_flush = 1'b0;
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
        data_sram_data_ok = 1'b1; data_sram_rdata = r1;
        #1;
        chk("fl_drop1", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("fl_drop1_busy", 128'(ms_load_busy), 128'(1'b1));
        tick();
        data_sram_rdata = r2;
        #1;
        chk("fl_drop2", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();
        data_sram_rdata = r3;
        #1;
        chk_out("fl_third", i, r3);
        tick();
        data_sram_data_ok = 1'b0;

        // address-error load: no request, leaves at once
        i = rnd(1'b1, 1'b0, 3'd0);
        i.ex = 1'b1; i.excode = 5'd4;
        enter(i);
        r = $urandom; data_sram_rdata = r;
        #1;
        chk_out("adel", i, r);
        chk("adel_busy", 128'(ms_load_busy), 128'(1'b0));
        tick();
        #1;
        chk("adel_gone", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("adel_eret_gone", 128'(ms_ex_eret), 128'(1'b0));

        // faulting store that would have requested: still ready at once
        i = rnd(1'b0, 1'b1, 3'd0);
        i.ex = 1'b1;
        enter(i);
        #1;
        chk_out("ades", i, 32'h0);
        tick();
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        r = $urandom; data_sram_data_ok = 1'b1; data_sram_rdata = r;
        #1;
        chk_out("after_ex", i, r);
        tick();
        data_sram_data_ok = 1'b0;

        // reset while a load waits and one stale response is pending
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        #1;
        chk("rw_busy", 128'(ms_load_busy), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rw_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("rw_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rw_fwd_we", 128'(ms_fwd_bus[40:37]), 128'(4'b0));
        i = rnd(1'b1, 1'b1, 3'd0);
        enter(i);
        r = $urandom; data_sram_data_ok = 1'b1; data_sram_rdata = r;
        #1;
        chk_out("rw_cnt0", i, r);
        tick();
        data_sram_data_ok = 1'b0;

        // randomized loads, stores and ALU ops with response delays and WB stalls
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(2);
            i = rnd(k == 0, k != 2, 3'($urandom_range(4)));
            d = $urandom_range(2); w = $urandom_range(2); r = $urandom;
            enter(i);
            if (i.mem_req) begin
                for (int m = 0; m < d; m++) begin
                    #1;
                    chk("rnd_busy", 128'(ms_load_busy), 128'(i.is_load));
                    chk("rnd_wait", 128'(ms_to_ws_valid), 128'(1'b0));
                    tick();
                end
            end
            data_sram_data_ok = i.mem_req; data_sram_rdata = r; ws_allowin = (w == 0);
            #1;
            chk_out("rnd", i, r);
            for (int m = 0; m < w; m++) begin
                tick();
                data_sram_data_ok = 1'b0; data_sram_rdata = $urandom; ws_allowin = (m == w - 1);
                #1;
                chk_out("rnd_hold", i, r);
            end
            tick();
            data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
            #1;
            chk("rnd_gone", 128'(ms_to_ws_valid), 128'(1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
